// File: rtl/piso_serializer_pkg.sv
// Shared FSM encoding and counter sizing helper for the PISO serializer.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width for a count of n states; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_tick_gen.sv
// Bit-period prescaler: counts 0..DIV-1 while enabled; tc is high in the last cycle of the period.
// tc is decoded from registered state only, so it carries no path from upstream inputs.
module piso_serializer_bit_tick_gen
  import piso_serializer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int PW = cnt_width(DIV);
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [PW-1:0] presc;

  assign tc = en && (presc == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == TERM) ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Serializes one WIDTH-bit word per frame onto SER, DIV cycles per bit; frame is WIDTH*DIV cycles.
// Din_Ready only in IDLE, so upstream must hold Din_Valid until accepted; Done pulses in the first IDLE cycle.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_Valid,
  output logic             Din_Ready,
  output logic             SER,
  output logic             Bit_Tick,
  output logic             Busy,
  output logic             Done
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             done_q, done_nxt;
  logic             shifting;
  logic             accept;
  logic             tick;

  assign shifting = (state == ST_SHIFT);
  assign accept   = (state == ST_IDLE) && Din_Valid;

  piso_serializer_bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (Clk),
    .rst_n (RST),
    .clr   (accept),
    .en    (shifting),
    .tc    (tick)
  );

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    done_nxt    = 1'b0;
    if (state == ST_IDLE) begin
      if (Din_Valid) begin
        shreg_nxt   = Din;
        bit_cnt_nxt = '0;
        state_nxt   = ST_SHIFT;
      end
    end else if (tick) begin
      // Zero fill keeps the register clear once the frame has drained.
      shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      if (bit_cnt == LAST) begin
        bit_cnt_nxt = '0;
        state_nxt   = ST_IDLE;
        done_nxt    = 1'b1;
      end else begin
        bit_cnt_nxt = bit_cnt + 1'b1;
      end
    end
  end

  assign SER       = shifting && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign Bit_Tick  = tick;
  assign Busy      = shifting;
  assign Din_Ready = (state == ST_IDLE);
  assign Done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (DIV4/MSB, DIV1/LSB, DIV2/MSB) against a per-cycle frame model.
module tb_piso_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] din     [3];
  logic         din_vld [3];
  logic         rdy     [3];
  logic         ser     [3];
  logic         tick    [3];
  logic         busy    [3];
  logic         done    [3];
  logic [W-1:0] q       [3];
  int           ticks   [3] = '{0, 0, 0};

  int checks = 0;
  int errors = 0;

  function automatic int div_of(input int id);
    return (id == 0) ? 4 : (id == 1) ? 1 : 2;
  endfunction

  function automatic bit msb_of(input int id);
    return (id != 1);
  endfunction

  // Bit carried in cycle c of a frame: bit index c/div, taken from the chosen end of the word.
  function automatic logic model_ser(input logic [W-1:0] w, input int c, input int div, input bit m);
    int k;
    k = c / div;
    return m ? w[W-1-k] : w[k];
  endfunction

  // Expected {SER,Bit_Tick,Busy,Done,Din_Ready} in cycle c after the accept edge.
  function automatic logic [4:0] model_vec(input logic [W-1:0] w, input int c, input int div, input bit m);
    if (c < W * div)
      return {model_ser(w, c, div, m), ((c % div) == div - 1), 1'b1, 1'b0, 1'b0};
    return 5'b00011;
  endfunction

  piso_serializer #(.WIDTH(W), .DIV(4), .MSB_FIRST(1'b1)) u0 (
    .Clk(clk), .RST(rst_n), .Din(din[0]), .Din_Valid(din_vld[0]), .Din_Ready(rdy[0]),
    .SER(ser[0]), .Bit_Tick(tick[0]), .Busy(busy[0]), .Done(done[0]));
  piso_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b0)) u1 (
    .Clk(clk), .RST(rst_n), .Din(din[1]), .Din_Valid(din_vld[1]), .Din_Ready(rdy[1]),
    .SER(ser[1]), .Bit_Tick(tick[1]), .Busy(busy[1]), .Done(done[1]));
  piso_serializer #(.WIDTH(W), .DIV(2), .MSB_FIRST(1'b1)) u2 (
    .Clk(clk), .RST(rst_n), .Din(din[2]), .Din_Valid(din_vld[2]), .Din_Ready(rdy[2]),
    .SER(ser[2]), .Bit_Tick(tick[2]), .Busy(busy[2]), .Done(done[2]));

  // Downstream serial-in register: clocked on clk, enabled by Bit_Tick.
  for (genvar g = 0; g < 3; g++) begin : g_cap
    always @(posedge clk) begin
      if (tick[g]) begin
        q[g]     <= msb_of(g) ? {q[g][W-2:0], ser[g]} : {ser[g], q[g][W-1:1]};
        ticks[g] <= ticks[g] + 1;
      end
    end
  end

  task automatic run_frame(input int id, input logic [W-1:0] w, input string nm);
    int         div, t0;
    bit         m;
    logic [4:0] got, expv;
    div = div_of(id);
    m   = msb_of(id);
    @(posedge clk); #1 din[id] = w; din_vld[id] = 1'b1;
    @(posedge clk); #1 din_vld[id] = 1'b0; din[id] = W'($urandom); t0 = ticks[id];
    for (int c = 0; c <= W * div; c++) begin
      @(negedge clk);
      got  = {ser[id], tick[id], busy[id], done[id], rdy[id]};
      expv = model_vec(w, c, div, m);
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s cyc %0d got %b exp %b", nm, c, got, expv);
      end
      if (c == 2) din[id] = ~w;
    end
    checks++;
    if (q[id] !== w) begin
      errors++;
      $display("FAIL %s capture got %h exp %h", nm, q[id], w);
    end
    checks++;
    if (ticks[id] - t0 != W) begin
      errors++;
      $display("FAIL %s tick_count got %0d exp %0d", nm, ticks[id] - t0, W);
    end
  endtask

  task automatic test_reset;
    logic [4:0] got;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; din_vld[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      got = {ser[i], tick[i], busy[i], done[i], rdy[i]};
      checks++;
      if (got !== 5'b00001) begin
        errors++;
        $display("FAIL reset inst %0d got %b exp 00001", i, got);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        got = {ser[i], tick[i], busy[i], done[i], rdy[i]};
        checks++;
        if (got !== 5'b00001) begin
          errors++;
          $display("FAIL idle inst %0d cyc %0d got %b exp 00001", i, c, got);
        end
      end
    end
  endtask

  task automatic test_msb_div4;
    run_frame(0, 8'hA5, "msb_div4");
  endtask

  task automatic test_lsb_div1;
    run_frame(1, 8'h01, "lsb_div1");
  endtask

  task automatic test_back_to_back;
    logic [4:0]   got, expv;
    logic [W-1:0] w;
    int           f, l, t0;
    @(posedge clk); #1 din[2] = 8'hFF; din_vld[2] = 1'b1;
    @(posedge clk); #1 t0 = ticks[2];
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      f    = (c <= 16) ? 0 : 1;
      l    = c - 17 * f;
      w    = (f == 0) ? 8'hFF : 8'h00;
      expv = model_vec(w, l, 2, 1'b1);
      got  = {ser[2], tick[2], busy[2], done[2], rdy[2]};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %b exp %b", c, got, expv);
      end
      if (c == 3) din[2] = 8'h00;
      if (c == 17) din_vld[2] = 1'b0;
      if (c == 20) din[2] = 8'hFF;
    end
    checks++;
    if (q[2] !== 8'h00 || ticks[2] - t0 != 16) begin
      errors++;
      $display("FAIL back_to_back capture got %h/%0d exp 00/16", q[2], ticks[2] - t0);
    end
  endtask

  task automatic test_reset_midframe;
    logic [4:0] got, expv;
    @(posedge clk); #1 din[0] = 8'hC3; din_vld[0] = 1'b1;
    @(posedge clk); #1 din_vld[0] = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      expv = model_vec(8'hC3, c, 4, 1'b1);
      got  = {ser[0], tick[0], busy[0], done[0], rdy[0]};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL midreset_pre cyc %0d got %b exp %b", c, got, expv);
      end
    end
    #2 rst_n = 1'b0;
    #1 got = {ser[0], tick[0], busy[0], done[0], rdy[0]};
    checks++;
    if (got !== 5'b00001) begin
      errors++;
      $display("FAIL midreset_async got %b exp 00001", got);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      got = {ser[0], tick[0], busy[0], done[0], rdy[0]};
      checks++;
      if (got !== 5'b00001) begin
        errors++;
        $display("FAIL midreset_hold cyc %0d got %b exp 00001", c, got);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {ser[0], tick[0], busy[0], done[0], rdy[0]};
    checks++;
    if (got !== 5'b00001) begin
      errors++;
      $display("FAIL midreset_release got %b exp 00001", got);
    end
    run_frame(0, 8'h3C, "after_reset");
  endtask

  task automatic test_handshake;
    logic [4:0]   got, expv;
    logic [W-1:0] w;
    int           dones;
    w     = W'($urandom);
    dones = 0;
    @(posedge clk); #1 din[0] = w; din_vld[0] = 1'b1;
    @(posedge clk); #1 din_vld[0] = 1'b0;
    for (int c = 0; c <= W * 4 + 3; c++) begin
      @(negedge clk);
      expv = model_vec(w, (c > W * 4) ? W * 4 : c, 4, 1'b1);
      if (c > W * 4) expv[1] = 1'b0;
      got = {ser[0], tick[0], busy[0], done[0], rdy[0]};
      if (done[0] === 1'b1) dones++;
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL handshake cyc %0d got %b exp %b", c, got, expv);
      end
      if (c == 10) begin din[0] = ~w; din_vld[0] = 1'b1; end
      if (c == 11) din_vld[0] = 1'b0;
    end
    checks++;
    if (dones != 1 || q[0] !== w) begin
      errors++;
      $display("FAIL handshake done_count/capture got %0d/%h exp 1/%h", dones, q[0], w);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] w;
    for (int r = 0; r < 4; r++) begin
      for (int id = 0; id < 3; id++) begin
        w = W'($urandom);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        run_frame(id, w, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_div4();
    test_lsb_div1();
    test_back_to_back();
    test_reset_midframe();
    test_handshake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out source stage that produces the SER bit stream for the 8-bit serial-in shift register.
- Accepts one WIDTH-bit word per frame through a valid/ready handshake.
- Shifts the word out on SER, one bit per DIV clock cycles.
- Bit_Tick marks the sample point of each bit, so the downstream register can capture on Clk with Bit_Tick as its enable.

Parameters:
- WIDTH, 8, bits per frame (>=2).
- DIV, 4, Clk cycles per bit (>=1).
- MSB_FIRST, 1, 1 = Din[WIDTH-1] sent first; 0 = Din[0] sent first.

Ports:
- Clk  input  1  system clock, all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- Din  input  WIDTH  parallel word to transmit.
- Din_Valid  input  1  Din holds a word to send.
- Din_Ready  output  1  block can accept a word (IDLE).
- SER  output  1  serial data out.
- Bit_Tick  output  1  high in the last Clk cycle of each bit period.
- Busy  output  1  frame in progress.
- Done  output  1  one-cycle pulse after the last bit completes.

Behaviour:
- Reset (RST=0, async): state IDLE, shift reg=0, presc=0, bit_cnt=0. Outputs SER=0, Busy=0, Done=0, Bit_Tick=0, Din_Ready=1.
- States: IDLE, SHIFT. Two-state FSM; state register encoding comes from the package.
- IDLE:
  - Din_Ready=1, SER=0, Busy=0.
  - Accept when Din_Valid=1 at a rising edge: load Din into the shift reg, presc<=0, bit_cnt<=0, state<=SHIFT.
- SHIFT:
  - Din_Ready=0, Busy=1.
  - SER = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0]. SER is a registered-path output with no combinational path from Din.
  - presc increments every cycle.
  - Bit_Tick = (state==SHIFT && presc==DIV-1), decoded from registers only.
  - On the Bit_Tick edge: presc<=0, shift the register (toward MSB out or LSB out, zero fill), bit_cnt++.
  - On the Bit_Tick edge with bit_cnt==WIDTH-1: state<=IDLE and Done<=1 for exactly one cycle.
- Timing:
  - Accept at edge E0. Bit k is on SER for cycles [E0+k*DIV, E0+(k+1)*DIV-1].
  - Frame length is exactly WIDTH*DIV cycles. Exactly WIDTH Bit_Tick pulses per frame.
  - Done is high during the first IDLE cycle, coinciding with Din_Ready=1.
  - A new word can be accepted at the end of that cycle, so the minimum inter-frame gap is 1 cycle with SER=0.
- DIV=1: Bit_Tick is high every SHIFT cycle; frame length is WIDTH cycles.
- Din and Din_Valid are ignored during SHIFT. No queuing; the word is lost unless the upstream holds Din_Valid until Din_Ready.
- Din_Valid dropping before acceptance has no effect.
- Reset mid-frame: immediate abort. Outputs return to reset values; no Done pulse.
- Widths: presc uses max(1,$clog2(DIV)) bits; bit_cnt uses $clog2(WIDTH) bits. Neither wraps past its terminal value.

Decomposition:
- Package: state encoding constants (ST_IDLE=1'b0, ST_SHIFT=1'b1) and the width helper for presc/bit_cnt sizing.
- Sub-module bit_tick_gen: the DIV prescaler with sync clear, enable, and a terminal-count output (drives Bit_Tick). The FSM, shift register and bit counter stay in piso_serializer.

Test Plan (all scenarios use WIDTH=8):
- Reset, then idle: with RST low, then high and no Din_Valid -> SER=0, Din_Ready=1, Busy=0, Done=0, Bit_Tick=0 for 50 cycles.
- DIV=4, MSB_FIRST=1, Din=8'hA5 accepted -> SER = 1,0,1,0,0,1,0,1, each held 4 cycles. Bit_Tick pulses at cycles 3,7,...,31 after accept. Done at cycle 32. Bench shift register clocked on Clk, enabled by Bit_Tick, ends at Q=8'hA5.
- MSB_FIRST=0, DIV=1, Din=8'h01 -> SER = 1,0,0,0,0,0,0,0 on consecutive cycles. Done at cycle 8. Bench LSB-first capture yields 8'h01.
- Back-to-back: Din_Valid held high with 8'hFF then 8'h00 (DIV=2) -> 16 cycles of SER=1, one gap cycle SER=0 with Done=1, then 16 cycles of SER=0. Din changes during SHIFT do not alter the stream.
- Reset mid-frame: RST=0 during bit 3 of 8'hC3 -> SER, Busy and Bit_Tick go 0 asynchronously, no Done pulse. After release, Din_Ready=1 and a new frame 8'h3C transmits correctly.
- Handshake: Din_Valid pulsed for one cycle while Busy=1 -> ignored. The current frame completes unchanged and exactly one Done pulse occurs.
